// File: rtl/fixed_weight_pkg.sv
// Shared types and parameter sets for the fixed-weight error-vector sequencer.
package fixed_weight_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_GO,
        S_RUN,
        S_DONE
    } fwc_state_e;

    localparam int RETRY_W = 8;

    localparam int N_348864   = 3488;
    localparam int TAU_348864 = 64;
    localparam int M_348864   = 12;

    localparam int N_460896   = 4608;
    localparam int TAU_460896 = 96;
    localparam int M_460896   = 13;

    localparam int N_6688128   = 6688;
    localparam int TAU_6688128 = 128;
    localparam int M_6688128   = 13;

    localparam int N_8192128   = 8192;
    localparam int TAU_8192128 = 128;
    localparam int M_8192128   = 13;

endpackage

// File: rtl/fixed_weight_ctrl_if.sv
// Control, random-stream and generator handshake bundle for fixed_weight_ctrl.
interface fixed_weight_ctrl_if #(
    parameter int m      = 13,
    parameter int LOGTAU = 7
);
    logic                                  start;
    logic                                  busy;
    logic                                  done;
    logic                                  fail;
    logic [fixed_weight_pkg::RETRY_W-1:0]  retries;
    logic [m-1:0]                          rnd_data;
    logic                                  rnd_valid;
    logic                                  rnd_ready;
    logic                                  gen_init_mem;
    logic                                  gen_start;
    logic                                  gen_ready;
    logic                                  gen_collision;
    logic                                  gen_done;
    logic                                  gen_rd_en;
    logic [LOGTAU-1:0]                     gen_rd_addr;
    logic [m-1:0]                          location;

    modport slave (
        input  start, rnd_data, rnd_valid, gen_ready, gen_collision, gen_done,
               gen_rd_en, gen_rd_addr,
        output busy, done, fail, retries, rnd_ready, gen_init_mem, gen_start,
               location
    );

    modport master (
        output start, rnd_data, rnd_valid, gen_ready, gen_collision, gen_done,
               gen_rd_en, gen_rd_addr,
        input  busy, done, fail, retries, rnd_ready, gen_init_mem, gen_start,
               location
    );
endinterface

// File: rtl/fixed_weight_ctrl_loc_buf.sv
// TAU x m location register file: one synchronous write port, one registered
// read port with enable (output held when not enabled).
module loc_buf #(
    parameter int m      = 13,
    parameter int TAU    = 96,
    parameter int LOGTAU = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [LOGTAU-1:0] wr_addr_i,
    input  logic [m-1:0]      wr_data_i,
    input  logic              rd_en_i,
    input  logic [LOGTAU-1:0] rd_addr_i,
    output logic [m-1:0]      rd_data_o
);
    localparam logic [LOGTAU:0] TAU_C = (LOGTAU + 1)'(TAU);

    logic [m-1:0] mem_q [TAU];
    logic [m-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Indices past TAU-1 have no storage behind them and read back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            if ({1'b0, rd_addr_i} < TAU_C) begin
                rd_data_q <= mem_q[rd_addr_i];
            end else begin
                rd_data_q <= '0;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fixed_weight_ctrl.sv
// Sequencer for the fixed-weight error-vector generator: buffers TAU in-range
// locations, runs the generator clear/start handshake and retries on collision.
module fixed_weight_ctrl
    import fixed_weight_pkg::*;
#(
    parameter int m         = 13,
    parameter int N         = 4608,
    parameter int TAU       = 96,
    parameter int LOGTAU    = $clog2(TAU),
    parameter int MAX_RETRY = 255
) (
    input  logic               clk,
    input  logic               rst,
    fixed_weight_ctrl_if.slave bus
);
    localparam logic [LOGTAU:0]    TAU_C   = (LOGTAU + 1)'(TAU);
    localparam logic [m-1:0]       N_C     = m'(N);
    localparam logic [RETRY_W-1:0] MAX_C   = RETRY_W'(MAX_RETRY);
    // When N covers the whole m-bit range, N_C truncates and every word is valid.
    localparam bit                 ALL_IN  = (N >= (2 ** m));

    fwc_state_e         state_q, state_d;
    logic [LOGTAU:0]    fill_cnt_q, fill_cnt_d;
    logic [RETRY_W-1:0] retries_q, retries_d;
    logic               fail_q, fail_d;

    logic               rnd_ready;
    logic               in_range;
    logic               wr_en;

    assign rnd_ready = (state_q == S_FILL) && (fill_cnt_q < TAU_C);
    assign in_range  = ALL_IN || (bus.rnd_data < N_C);

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        retries_d  = retries_q;
        fail_d     = fail_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    retries_d  = '0;
                    fail_d     = 1'b0;
                    fill_cnt_d = '0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: state_d = S_FILL;
            S_FILL: begin
                if (bus.rnd_valid && rnd_ready && in_range) begin
                    wr_en      = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                end
                // Look-ahead on the count lets the last word and gen_ready
                // coincide, giving the TAU+2 start-to-gen_start minimum.
                if ((fill_cnt_d == TAU_C) && bus.gen_ready) begin
                    state_d = S_GO;
                end
            end
            S_GO: state_d = S_RUN;
            S_RUN: begin
                if (bus.gen_collision) begin
                    if (retries_q >= MAX_C) begin
                        fail_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        retries_d  = retries_q + 1'b1;
                        fill_cnt_d = '0;
                        state_d    = S_FILL;
                    end
                end else if (bus.gen_done) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fill_cnt_q <= '0;
            retries_q  <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            retries_q  <= retries_d;
            fail_q     <= fail_d;
        end
    end

    loc_buf #(
        .m      (m),
        .TAU    (TAU),
        .LOGTAU (LOGTAU)
    ) u_loc_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (fill_cnt_q[LOGTAU-1:0]),
        .wr_data_i (bus.rnd_data),
        .rd_en_i   (bus.gen_rd_en),
        .rd_addr_i (bus.gen_rd_addr),
        .rd_data_o (bus.location)
    );

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.fail         = fail_q;
    assign bus.retries      = retries_q;
    assign bus.rnd_ready    = rnd_ready;
    assign bus.gen_init_mem = (state_q == S_CLEAR);
    assign bus.gen_start    = (state_q == S_GO);

endmodule

// File: tb/tb_fixed_weight_ctrl.sv
// Directed self-checking bench for fixed_weight_ctrl (N=4608, TAU=96, MAX_RETRY=2).
module tb_fixed_weight_ctrl;
    localparam int M  = 13;
    localparam int LT = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fixed_weight_ctrl_if #(.m(M), .LOGTAU(LT)) b ();

    fixed_weight_ctrl #(
        .m         (M),
        .N         (4608),
        .TAU       (96),
        .LOGTAU    (LT),
        .MAX_RETRY (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    int n_cmp  = 0;
    int n_err  = 0;
    int n_init = 0;
    int n_gs   = 0;
    int n_done = 0;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (b.gen_init_mem === 1'b1) n_init <= n_init + 1;
        if (b.gen_start === 1'b1)    n_gs   <= n_gs + 1;
        if (b.done === 1'b1)         n_done <= n_done + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            b.rnd_valid = 1'b1;
            b.rnd_data  = M'(base + i);
            tick();
        end
        b.rnd_valid = 1'b0;
    endtask

    task automatic read_loc(input string tag, input int addr, input int exp);
        b.gen_rd_en   = 1'b1;
        b.gen_rd_addr = LT'(addr);
        tick();
        b.gen_rd_en   = 1'b0;
        chk(tag, b.location, exp);
    endtask

    // start at cycle 0, words 0..95 from cycle 2, gen_ready during cycle 150.
    task automatic clean_run(input string p);
        int i0, g0, d0;
        i0 = n_init; g0 = n_gs; d0 = n_done;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk({p, "init_mem_c1"}, b.gen_init_mem, 1);
        chk({p, "busy_c1"}, b.busy, 1);
        chk({p, "ready_c1"}, b.rnd_ready, 0);
        tick();
        chk({p, "ready_c2"}, b.rnd_ready, 1);
        chk({p, "init_mem_c2"}, b.gen_init_mem, 0);
        feed(0, 96);
        chk({p, "ready_full"}, b.rnd_ready, 0);
        chk({p, "gs_wait"}, b.gen_start, 0);
        repeat (52) tick();
        chk({p, "gs_c150"}, b.gen_start, 0);
        b.gen_ready = 1'b1;
        tick();
        chk({p, "gs_c151"}, b.gen_start, 1);
        b.gen_ready = 1'b0;
        tick();
        chk({p, "gs_c152"}, b.gen_start, 0);
        chk({p, "init_pulses"}, n_init - i0, 1);
        chk({p, "gs_pulses"}, n_gs - g0, 1);
        read_loc({p, "loc5"}, 5, 5);
        b.gen_rd_addr = LT'(77);
        tick();
        chk({p, "loc_hold"}, b.location, 5);
        read_loc({p, "loc95"}, 95, 95);
        chk({p, "done_run"}, b.done, 0);
        b.gen_done = 1'b1;
        tick();
        b.gen_done = 1'b0;
        chk({p, "done"}, b.done, 1);
        chk({p, "busy_done"}, b.busy, 1);
        chk({p, "fail"}, b.fail, 0);
        chk({p, "retries"}, b.retries, 0);
        tick();
        chk({p, "done_low"}, b.done, 0);
        chk({p, "busy_low"}, b.busy, 0);
        chk({p, "done_pulses"}, n_done - d0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int i0, g0, d0;
        b.start = 1'b0; b.rnd_valid = 1'b0; b.rnd_data = '0;
        b.gen_ready = 1'b0; b.gen_collision = 1'b0; b.gen_done = 1'b0;
        b.gen_rd_en = 1'b0; b.gen_rd_addr = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", b.busy, 0);
        chk("rst_ready", b.rnd_ready, 0);
        rst = 1'b1;
        tick();
        tick();
        chk("idle_busy", b.busy, 0);
        chk("idle_done", b.done, 0);
        chk("idle_fail", b.fail, 0);
        chk("idle_ready", b.rnd_ready, 0);
        chk("idle_init", b.gen_init_mem, 0);
        chk("idle_gs", b.gen_start, 0);
        chk("idle_retries", b.retries, 0);
        chk("idle_loc", b.location, 0);

        clean_run("clean_");

        // Out-of-range filtering, then collision and retry
        i0 = n_init; g0 = n_gs; d0 = n_done;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        tick();
        feed(4608, 1);
        feed(8191, 1);
        feed(7, 1);
        feed(4607, 1);
        chk("flt_ready_2", b.rnd_ready, 1);
        feed(1000, 93);
        chk("flt_ready_95", b.rnd_ready, 1);
        feed(1093, 1);
        chk("flt_ready_96", b.rnd_ready, 0);
        b.gen_ready = 1'b1;
        tick();
        b.gen_ready = 1'b0;
        chk("flt_gs", b.gen_start, 1);
        tick();
        read_loc("flt_loc0", 0, 7);
        read_loc("flt_loc1", 1, 4607);
        read_loc("flt_loc2", 2, 1000);
        read_loc("flt_loc95", 95, 1093);

        b.gen_collision = 1'b1;
        tick();
        b.gen_collision = 1'b0;
        chk("col_retries", b.retries, 1);
        chk("col_ready", b.rnd_ready, 1);
        chk("col_init", b.gen_init_mem, 0);
        chk("col_busy", b.busy, 1);
        chk("col_done", b.done, 0);
        b.gen_ready = 1'b1;
        feed(2000, 96);
        chk("col_gs2", b.gen_start, 1);
        b.gen_ready = 1'b0;
        tick();
        read_loc("col_loc0", 0, 2000);
        read_loc("col_loc95", 95, 2095);
        b.gen_done = 1'b1;
        tick();
        b.gen_done = 1'b0;
        chk("col_donepulse", b.done, 1);
        chk("col_fail", b.fail, 0);
        chk("col_retries_end", b.retries, 1);
        tick();
        chk("col_init_pulses", n_init - i0, 1);
        chk("col_gs_pulses", n_gs - g0, 2);
        chk("col_done_pulses", n_done - d0, 1);

        // Collision on every attempt with MAX_RETRY = 2
        g0 = n_gs; d0 = n_done;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        tick();
        b.gen_ready = 1'b1;
        for (int a = 0; a < 3; a++) begin
            feed(a * 100, 96);
            chk("mr_gs", b.gen_start, 1);
            tick();
            b.gen_collision = 1'b1;
            tick();
            b.gen_collision = 1'b0;
            if (a < 2) begin
                chk("mr_retries", b.retries, a + 1);
                chk("mr_ready", b.rnd_ready, 1);
                chk("mr_nodone", b.done, 0);
            end else begin
                chk("mr_done", b.done, 1);
                chk("mr_fail", b.fail, 1);
                chk("mr_retries_sat", b.retries, 2);
            end
        end
        b.gen_ready = 1'b0;
        tick();
        chk("mr_gs_pulses", n_gs - g0, 3);
        chk("mr_done_pulses", n_done - d0, 1);
        chk("mr_busy_idle", b.busy, 0);
        chk("mr_fail_held", b.fail, 1);

        // Reset mid-FILL with rnd_valid high
        d0 = n_done;
        b.start = 1'b1;
        tick();
        b.start = 1'b0;
        chk("rs_fail_clr", b.fail, 0);
        chk("rs_retries_clr", b.retries, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            b.rnd_valid = 1'b1;
            b.rnd_data  = M'(300 + i);
            tick();
        end
        chk("rs_ready_pre", b.rnd_ready, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("rs_ready", b.rnd_ready, 0);
        chk("rs_busy", b.busy, 0);
        chk("rs_done", b.done, 0);
        chk("rs_init", b.gen_init_mem, 0);
        chk("rs_gs", b.gen_start, 0);
        chk("rs_loc", b.location, 0);
        b.rnd_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rs_no_done", n_done - d0, 0);
        chk("rs_idle_ready", b.rnd_ready, 0);
        clean_run("rs_");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
